// File: rtl/targ_pred_assoc_pkg.sv
// Shared types, widths and address helpers for the set-associative indirect
// target predictor.
package core;

  localparam int REQ_PORTS = 3;
  localparam int SETS      = 32;
  localparam int WAYS      = 4;
  localparam int TAG_BITS  = 8;
  localparam int CONF_BITS = 2;
  localparam int XLEN      = 32;

  localparam int IDX_W = $clog2(SETS);
  localparam int CNT_W = $clog2(WAYS + 1);
  localparam int WAY_W = $clog2(WAYS);

  localparam logic [CONF_BITS-1:0] CONF_MAX = '1;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] base_pc;
  } tpa_req_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] base_pc;
    logic [XLEN-1:0] targ_pc;
  } tpa_fb_t;

  typedef struct packed {
    logic                            valid;
    logic [CNT_W-1:0]                pred_cnt;
    logic [WAYS-1:0][XLEN-1:0]       pred_pc;
    logic [WAYS-1:0][CONF_BITS-1:0]  pred_conf;
  } tpa_rsp_t;

  localparam tpa_rsp_t tpa_rsp_rst = '0;

  typedef struct packed {
    logic                 valid;
    logic [TAG_BITS-1:0]  tag;
    logic [XLEN-1:0]      targ;
    logic [CONF_BITS-1:0] conf;
  } tpa_entry_t;

  typedef tpa_entry_t [WAYS-1:0] tpa_set_t;

  function automatic logic [IDX_W-1:0] pc_index(input logic [XLEN-1:0] pc);
    return pc[IDX_W+1:2];
  endfunction

  function automatic logic [TAG_BITS-1:0] pc_tag(input logic [XLEN-1:0] pc);
    return pc[IDX_W+1+TAG_BITS:IDX_W+2];
  endfunction

endpackage

// File: rtl/targ_pred_assoc_if.sv
// Fetch-side lookup, retire-side feedback and flush control bundle.
interface tpa_if;
  import core::*;

  logic     en;
  logic     flush_req;
  logic     flush_busy;
  tpa_req_t targ_pred_req [REQ_PORTS];
  tpa_fb_t  targ_pred_fb;
  tpa_rsp_t targ_pred_rsp [REQ_PORTS];

  modport master (
    output en, flush_req, targ_pred_req, targ_pred_fb,
    input  flush_busy, targ_pred_rsp
  );

  modport slave (
    input  en, flush_req, targ_pred_req, targ_pred_fb,
    output flush_busy, targ_pred_rsp
  );

endinterface

// File: rtl/targ_pred_assoc_rank.sv
// Combinational ranking of one set: tag-matching ways ordered by confidence
// (descending, lower way wins ties) and packed into the low slots.
module tpa_rank
  import core::*;
(
  input  tpa_set_t                       ways_in,
  input  logic [TAG_BITS-1:0]            tag,
  output logic [CNT_W-1:0]               pred_cnt,
  output logic [WAYS-1:0][XLEN-1:0]      pred_pc,
  output logic [WAYS-1:0][CONF_BITS-1:0] pred_conf
);

  logic [WAYS-1:0] match;

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      match[w] = ways_in[w].valid && (ways_in[w].tag == tag);
    end
  end

  // Each match's slot is the number of matches that outrank it.
  always_comb begin
    logic [CNT_W-1:0] rank;
    rank      = '0;
    pred_cnt  = '0;
    pred_pc   = '0;
    pred_conf = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (match[w]) begin
        rank = '0;
        for (int j = 0; j < WAYS; j++) begin
          if (match[j] && ((ways_in[j].conf > ways_in[w].conf) ||
                           ((ways_in[j].conf == ways_in[w].conf) && (j < w)))) begin
            rank = rank + CNT_W'(1);
          end
        end
        pred_pc[rank[WAY_W-1:0]]   = ways_in[w].targ;
        pred_conf[rank[WAY_W-1:0]] = ways_in[w].conf;
        pred_cnt = pred_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/targ_pred_assoc.sv
// Set-associative, confidence-ranked indirect target predictor: multi-port
// registered lookup, retire-side training and a one-set-per-cycle flush.
module targ_pred_assoc
  import core::*;
(
  input  logic clk,
  input  logic rst,
  tpa_if.slave bus
);

  typedef enum logic {IDLE, FLUSH} flush_state_t;

  function automatic logic [CONF_BITS-1:0] conf_inc(input logic [CONF_BITS-1:0] c);
    return (c == CONF_MAX) ? c : c + CONF_BITS'(1);
  endfunction

  function automatic logic [CONF_BITS-1:0] conf_dec(input logic [CONF_BITS-1:0] c);
    return (c == '0) ? c : c - CONF_BITS'(1);
  endfunction

  flush_state_t     state, state_nxt;
  logic [IDX_W-1:0] fcnt, fcnt_nxt;
  logic             clr_en;

  tpa_set_t tbl [SETS];

  assign bus.flush_busy = (state == FLUSH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    clr_en    = 1'b0;
    if (bus.en) begin
      case (state)
        IDLE: begin
          if (bus.flush_req) begin
            state_nxt = FLUSH;
            fcnt_nxt  = '0;
          end
        end
        FLUSH: begin
          clr_en = 1'b1;
          if (bus.flush_req) begin
            fcnt_nxt = '0;
          end else if (fcnt == IDX_W'(SETS - 1)) begin
            state_nxt = IDLE;
            fcnt_nxt  = '0;
          end else begin
            fcnt_nxt = fcnt + IDX_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Feedback: hit / install / victim-or-hysteresis for the addressed set.
  logic                fb_apply;
  logic [IDX_W-1:0]    fb_idx;
  logic [TAG_BITS-1:0] fb_tag;
  tpa_set_t            fb_set, fb_set_nxt;
  logic [WAYS-1:0]     fb_tmatch, fb_hit;
  logic                has_inv;
  logic [WAY_W-1:0]    inv_way, vic_way;
  logic [CONF_BITS-1:0] vic_conf;

  assign fb_apply = bus.en && bus.targ_pred_fb.valid && (state == IDLE);
  assign fb_idx   = pc_index(bus.targ_pred_fb.base_pc);
  assign fb_tag   = pc_tag(bus.targ_pred_fb.base_pc);
  assign fb_set   = tbl[fb_idx];

  always_comb begin
    fb_set_nxt = fb_set;
    fb_tmatch  = '0;
    fb_hit     = '0;
    has_inv    = 1'b0;
    inv_way    = '0;
    vic_way    = '0;
    vic_conf   = fb_set[0].conf;
    for (int w = 0; w < WAYS; w++) begin
      fb_tmatch[w] = fb_set[w].valid && (fb_set[w].tag == fb_tag);
      fb_hit[w]    = fb_tmatch[w] && (fb_set[w].targ == bus.targ_pred_fb.targ_pc);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!fb_set[w].valid) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
    for (int w = 1; w < WAYS; w++) begin
      if (fb_set[w].conf < vic_conf) begin
        vic_conf = fb_set[w].conf;
        vic_way  = WAY_W'(w);
      end
    end

    if (|fb_hit) begin
      for (int w = 0; w < WAYS; w++) begin
        if (fb_hit[w])         fb_set_nxt[w].conf = conf_inc(fb_set[w].conf);
        else if (fb_tmatch[w]) fb_set_nxt[w].conf = conf_dec(fb_set[w].conf);
      end
    end else if (has_inv) begin
      fb_set_nxt[inv_way] = '{valid: 1'b1, tag: fb_tag,
                              targ: bus.targ_pred_fb.targ_pc, conf: CONF_BITS'(1)};
    end else if (vic_conf == '0) begin
      fb_set_nxt[vic_way] = '{valid: 1'b1, tag: fb_tag,
                              targ: bus.targ_pred_fb.targ_pc, conf: CONF_BITS'(1)};
    end else begin
      for (int w = 0; w < WAYS; w++) begin
        fb_set_nxt[w].conf = conf_dec(fb_set[w].conf);
      end
    end
  end

  // Flush clearing and training never coincide: training is IDLE-only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        tbl[s] <= '0;
      end
    end else begin
      if (clr_en) begin
        for (int w = 0; w < WAYS; w++) begin
          tbl[fcnt][w].valid <= 1'b0;
          tbl[fcnt][w].conf  <= '0;
        end
      end
      if (fb_apply) begin
        tbl[fb_idx] <= fb_set_nxt;
      end
    end
  end

  // Stage p0: per-port set read and ranking against pre-update state.
  tpa_rsp_t rsp_p0 [REQ_PORTS];
  tpa_rsp_t rsp_p1 [REQ_PORTS];

  for (genvar p = 0; p < REQ_PORTS; p++) begin : g_port
    logic [CNT_W-1:0]               rk_cnt;
    logic [WAYS-1:0][XLEN-1:0]      rk_pc;
    logic [WAYS-1:0][CONF_BITS-1:0] rk_conf;

    tpa_rank u_rank (
      .ways_in   (tbl[pc_index(bus.targ_pred_req[p].base_pc)]),
      .tag       (pc_tag(bus.targ_pred_req[p].base_pc)),
      .pred_cnt  (rk_cnt),
      .pred_pc   (rk_pc),
      .pred_conf (rk_conf)
    );

    always_comb begin
      rsp_p0[p] = tpa_rsp_rst;
      if (bus.en && bus.targ_pred_req[p].valid) begin
        rsp_p0[p].valid = 1'b1;
        if (state == IDLE) begin
          rsp_p0[p].pred_cnt  = rk_cnt;
          rsp_p0[p].pred_pc   = rk_pc;
          rsp_p0[p].pred_conf = rk_conf;
        end
      end
    end

    // Stage p1: registered response.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) rsp_p1[p] <= tpa_rsp_rst;
      else     rsp_p1[p] <= rsp_p0[p];
    end

    assign bus.targ_pred_rsp[p] = rsp_p1[p];
  end

endmodule

// File: doc/targ_pred_assoc.md
Name: targ_pred_assoc

Overview:
- Set-associative, confidence-ranked indirect-jump target predictor for the fetch stage.
- Serves req_ports independent lookups per cycle with one-cycle registered latency.
- Learns from a single retire-side feedback channel.
- Adds tag matching, saturating per-entry confidence, victim selection and a multi-cycle flush engine.

Parameters:
- req_ports, 3, number of lookup ports.
- sets, 32, number of sets; power of two, >= 2.
- ways, 4, entries per set; also the maximum candidates returned per response.
- tag_bits, 8, partial-tag width taken from base_pc above the index.
- conf_bits, 2, width of the saturating confidence counter; conf_max = 2^conf_bits - 1.
- xlen, 32, PC width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable; when low, state holds, feedback is dropped and responses are invalid next cycle.
- flush_req  in  1  one-cycle pulse; starts invalidation of the whole table.
- flush_busy  out  1  high while the flush engine is running.
- targ_pred_req  in  core::tpa_req_t [req_ports]  {valid, base_pc[xlen]}.
- targ_pred_fb  in  core::tpa_fb_t  {valid, base_pc[xlen], targ_pc[xlen]}.
- targ_pred_rsp  out  core::tpa_rsp_t [req_ports]  {valid, pred_cnt[clog2(ways+1)], pred_pc[ways][xlen], pred_conf[ways][conf_bits]}.

Behaviour:
- Addressing: set index = base_pc[clog2(sets)+1:2]; tag = base_pc[clog2(sets)+1+tag_bits : clog2(sets)+2].
- Entry contents: {valid, tag, targ_pc, conf}.
- Reset, asynchronous: all entries have valid=0, conf=0 and tag/targ=0. All rsp outputs equal core::tpa_rsp_rst (valid=0, pred_cnt=0, all pc and conf fields 0). flush_busy=0. Flush counter=0.
- Lookup:
  - Port i presenting valid in cycle N gets rsp[i].valid=1 in cycle N+1, registered.
  - The response contains every valid way whose tag matches. Candidates are sorted by conf descending; ties go to the lower way index.
  - Candidates are packed into pred_pc[0..pred_cnt-1]. Unused slots are 0.
  - Duplicate targ_pc values within a set cannot occur; feedback guarantees uniqueness.
  - No tag hit gives valid=1, pred_cnt=0.
  - Ports are independent and may hit the same set in the same cycle.
- Lookup/feedback ordering: a lookup reads pre-update state when feedback updates the same set in the same cycle. There is no forwarding.
- Feedback (en && fb.valid && !flush_busy), applied at the clock edge:
  - Hit: valid, tag match and targ_pc match. conf increments, saturating at conf_max. Every other tag-matching way in the set decrements, saturating at 0.
  - Miss with an invalid way: install in the lowest-index invalid way with conf=1.
  - Miss with the set full: the victim is the way with minimum conf (lowest index on ties).
    - Victim conf==0: overwrite it with conf=1.
    - Otherwise: decrement every way in the set by 1 and do not install (hysteresis).
- Flush FSM:
  - States: IDLE and FLUSH.
  - IDLE -> FLUSH on flush_req. The counter is loaded with 0 and flush_busy goes high in the next cycle.
  - In FLUSH, one set per cycle is invalidated (all ways valid=0, conf=0) and the counter increments.
  - Leaving FLUSH: after set sets-1 is cleared, return to IDLE. flush_busy is high for exactly `sets` cycles.
  - During FLUSH, lookups return valid=1, pred_cnt=0 and feedback is dropped.
  - flush_req while already in FLUSH restarts the counter at 0.
  - en low freezes the FSM and counter.
- Reset mid-flush: returns to IDLE immediately with the table cleared.
- Widths: counters are unsigned; saturation is checked before increment/decrement, so no wrap is ever permitted.

Decomposition:
- Package core holds:
  - tpa_req_t, tpa_fb_t, tpa_rsp_t and tpa_rsp_rst.
  - Localparam-derived widths: set index, tag, pred_cnt.
- One sub-module, tpa_rank: purely combinational. It sorts a set's ways by conf with lower-index tie-break and packs the matches. It is instantiated once per request port.
- Set update, victim selection and the flush FSM stay in the top module.

Test Plan:
- Reset, then lookup pc 0x100 -> next cycle valid=1, pred_cnt=0, all pred_pc=0.
- Feedback (0x100 -> 0x4000) three times, then lookup 0x100 -> pred_cnt=1, pred_pc[0]=0x4000, pred_conf[0]=3 (saturated after 1+1+1).
- Fill one set with 4 targets, with conf 1/1/1 and target 0x5000 raised to 3. Then feed a 5th target -> no install, confs become 0/0/0/2. The 5th target again -> installs in way 0 with conf=1. Lookup order: 0x5000 first, then the new target.
- Same-cycle feedback and lookup to the same set -> the lookup returns old contents; a lookup one cycle later sees the update.
- flush_req with sets=32 -> flush_busy high exactly 32 cycles. Feedback during flush is ignored. Lookups during and after flush give pred_cnt=0.
- Assert rst at flush cycle 10 -> flush_busy=0 and all rsp equal reset values immediately. The previously trained pc returns pred_cnt=0.
